// File: rtl/mem_port_scheduler.sv
// Shares the single DDR port between fetch, store and load requesters.
// Fixed priority load > store > fetch, with an aging counter that forces a fetch grant.
module mem_port_scheduler #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic         clock,
   input  logic         reset,

   input  logic         pc_index_valid,
   input  logic [18:0]  pc_index,
   output logic         pc_index_ready,
   output logic [511:0] pc_read_inst,
   output logic         pc_operation_done,

   input  logic         opstore_index_valid,
   input  logic [18:0]  opstore_index,
   input  logic [63:0]  opstore_write_mask,
   input  logic [63:0]  opstore_write_data,
   output logic         opstore_index_ready,
   output logic         opstore_operation_done,

   input  logic         opload_index_valid,
   input  logic [18:0]  opload_index,
   output logic         opload_index_ready,
   output logic [63:0]  opload_read_data,
   output logic         opload_operation_done,

   output logic         ddr_chip_enable,
   output logic [18:0]  ddr_index,
   output logic         ddr_write_enable,
   output logic         ddr_burst_mode,
   output logic [63:0]  ddr_opstore_write_mask,
   output logic [63:0]  ddr_opstore_write_data,
   input  logic [63:0]  ddr_opload_read_data,
   input  logic [511:0] ddr_pc_read_inst,
   input  logic         ddr_operation_done,
   input  logic         ddr_ready,

   output logic         busy,
   output logic [1:0]   owner
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [1:0] OWN_NONE  = 2'd0;
   localparam logic [1:0] OWN_FETCH = 2'd1;
   localparam logic [1:0] OWN_STORE = 2'd2;
   localparam logic [1:0] OWN_LOAD  = 2'd3;
   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   state_t         state_reg;
   logic [1:0]     owner_reg;
   logic [3:0]     starve_cnt_reg;
   logic [18:0]    ddr_index_reg;
   logic           ddr_write_enable_reg;
   logic           ddr_burst_mode_reg;
   logic [63:0]    ddr_mask_reg;
   logic [63:0]    ddr_data_reg;
   logic [511:0]   pc_read_inst_reg;
   logic [63:0]    opload_read_data_reg;
   logic           pc_done_reg;
   logic           opstore_done_reg;
   logic           opload_done_reg;

   // Grant vector bit order: 0 fetch, 1 store, 2 load.
   logic           force_fetch;
   logic [2:0]     grant_vec;
   logic [2:0]     ready_vec;
   logic [1:0]     grant_owner;
   logic [18:0]    grant_index;
   logic [3:0]     starve_cnt_next;

   always_comb begin
      force_fetch  = pc_index_valid && (starve_cnt_reg == STARVE_MAX);
      grant_vec    = 3'b000;
      grant_owner  = OWN_NONE;
      grant_index  = 19'd0;
      if (force_fetch) begin
         grant_vec   = 3'b001;
         grant_owner = OWN_FETCH;
         grant_index = pc_index;
      end else if (opload_index_valid) begin
         grant_vec   = 3'b100;
         grant_owner = OWN_LOAD;
         grant_index = opload_index;
      end else if (opstore_index_valid) begin
         grant_vec   = 3'b010;
         grant_owner = OWN_STORE;
         grant_index = opstore_index;
      end else if (pc_index_valid) begin
         grant_vec   = 3'b001;
         grant_owner = OWN_FETCH;
         grant_index = pc_index;
      end
   end

   // A load/store win only ages fetch if fetch was actually waiting.
   always_comb begin
      starve_cnt_next = 4'd0;
      if (grant_vec[0] || !pc_index_valid)
         starve_cnt_next = 4'd0;
      else if (starve_cnt_reg != 4'hF)
         starve_cnt_next = starve_cnt_reg + 4'd1;
      else
         starve_cnt_next = starve_cnt_reg;
   end

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_ready
         assign ready_vec[gi] = (state_reg == IDLE) && grant_vec[gi];
      end
   endgenerate

   assign pc_index_ready      = ready_vec[0];
   assign opstore_index_ready = ready_vec[1];
   assign opload_index_ready  = ready_vec[2];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg            <= IDLE;
         owner_reg            <= OWN_NONE;
         starve_cnt_reg       <= 4'd0;
         ddr_index_reg        <= 19'd0;
         ddr_write_enable_reg <= 1'b0;
         ddr_burst_mode_reg   <= 1'b0;
         ddr_mask_reg         <= 64'd0;
         ddr_data_reg         <= 64'd0;
         pc_read_inst_reg     <= 512'd0;
         opload_read_data_reg <= 64'd0;
         pc_done_reg          <= 1'b0;
         opstore_done_reg     <= 1'b0;
         opload_done_reg      <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (grant_vec != 3'b000) begin
                  owner_reg            <= grant_owner;
                  ddr_index_reg        <= grant_index;
                  ddr_write_enable_reg <= grant_vec[1];
                  ddr_burst_mode_reg   <= grant_vec[0];
                  ddr_mask_reg         <= grant_vec[1] ? opstore_write_mask : 64'd0;
                  ddr_data_reg         <= grant_vec[1] ? opstore_write_data : 64'd0;
                  starve_cnt_reg       <= starve_cnt_next;
                  state_reg            <= ISSUE;
               end
            end
            ISSUE: begin
               if (ddr_ready)
                  state_reg <= WAIT;
            end
            WAIT: begin
               if (ddr_operation_done) begin
                  if (owner_reg == OWN_FETCH)
                     pc_read_inst_reg <= ddr_pc_read_inst;
                  if (owner_reg == OWN_LOAD)
                     opload_read_data_reg <= ddr_opload_read_data;
                  pc_done_reg      <= (owner_reg == OWN_FETCH);
                  opstore_done_reg <= (owner_reg == OWN_STORE);
                  opload_done_reg  <= (owner_reg == OWN_LOAD);
                  state_reg        <= RESP;
               end
            end
            RESP: begin
               pc_done_reg          <= 1'b0;
               opstore_done_reg     <= 1'b0;
               opload_done_reg      <= 1'b0;
               owner_reg            <= OWN_NONE;
               ddr_index_reg        <= 19'd0;
               ddr_write_enable_reg <= 1'b0;
               ddr_burst_mode_reg   <= 1'b0;
               ddr_mask_reg         <= 64'd0;
               ddr_data_reg         <= 64'd0;
               state_reg            <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Issue pulse must track ddr_ready in the same cycle, so it stays combinational.
   assign ddr_chip_enable        = (state_reg == ISSUE) && ddr_ready;
   assign ddr_index              = ddr_index_reg;
   assign ddr_write_enable       = ddr_write_enable_reg;
   assign ddr_burst_mode         = ddr_burst_mode_reg;
   assign ddr_opstore_write_mask = ddr_mask_reg;
   assign ddr_opstore_write_data = ddr_data_reg;
   assign pc_read_inst           = pc_read_inst_reg;
   assign opload_read_data       = opload_read_data_reg;
   assign pc_operation_done      = pc_done_reg;
   assign opstore_operation_done = opstore_done_reg;
   assign opload_operation_done  = opload_done_reg;
   assign busy                   = (state_reg != IDLE);
   assign owner                  = owner_reg;

endmodule

// File: doc/mem_port_scheduler.md
# mem_port_scheduler

Sequencer and arbiter sharing the single DDR port between three requesters: instruction-fetch burst reads (pc), LSU stores (opstore) and LSU loads (opload). It accepts one request at a time over a valid/ready handshake and latches its index and data. It drives one DDR operation, waits for completion, then returns read data and a done pulse to the owning channel. Priority is fixed load > store > fetch, with an aging counter that guarantees fetch forward progress; the block sits between the backend/frontend memory clients and the DDR model at the core top level.

## Interface
- STARVE_LIMIT, 4: consecutive non-fetch grants tolerated while fetch is pending before fetch is forced to win (1..15).
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pc_index_valid / opstore_index_valid / opload_index_valid  in  1 each  request valid.
- pc_index / opstore_index / opload_index  in  19 each  DDR index.
- opstore_write_mask, opstore_write_data  in  64 each  store mask/data.
- pc_index_ready / opstore_index_ready / opload_index_ready  out  1 each  request accepted this cycle when valid&ready.
- pc_read_inst  out  512  fetch burst data, held until next fetch completes.
- opload_read_data  out  64  load data, held until next load completes.
- pc_operation_done / opstore_operation_done / opload_operation_done  out  1 each  one-cycle completion pulse.
- ddr_chip_enable  out  1  one-cycle issue pulse.
- ddr_index  out  19; ddr_write_enable  out  1; ddr_burst_mode  out  1.
- ddr_opstore_write_mask, ddr_opstore_write_data  out  64 each.
- ddr_opload_read_data  in  64; ddr_pc_read_inst  in  512.
- ddr_operation_done  in  1  DDR completion strobe; ddr_ready  in  1  DDR can accept an operation.
- busy  out  1  state != IDLE; owner  out  2  0 none, 1 fetch, 2 store, 3 load.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: the arbiter picks one winner among the valid channels. Only the winner's ready is high (combinational from valids). Other readys are always 0. On the accepting edge: latch index, mask, data and owner; go to ISSUE.
- Arbitration order: load, then store, then fetch. Exception: if starve_cnt == STARVE_LIMIT and pc_index_valid=1, fetch wins.
- starve_cnt (4 bits, saturating):
  - +1 on each load/store grant while pc_index_valid=1.
  - Cleared on a fetch grant, or on any grant while pc_index_valid=0.
- ISSUE: if ddr_ready=1, assert ddr_chip_enable for exactly that cycle and go to WAIT; otherwise hold in ISSUE with chip_enable=0.
- WAIT: on ddr_operation_done=1, capture ddr_pc_read_inst (fetch) or ddr_opload_read_data (load) into the output register and go to RESP.
- RESP: assert the owner's *_operation_done for one cycle; clear owner; go to IDLE. No acceptance occurs in RESP.
- DDR outputs are registered from the latched request and held stable from ISSUE through RESP:
  - ddr_write_enable=1 only for store.
  - ddr_burst_mode=1 only for fetch.
  - mask/data pass through only for store; otherwise 0.
- ddr_operation_done is ignored in IDLE, ISSUE and RESP. This covers stale completions after reset.

## Timing
- Reset values: all readys, dones, ddr_chip_enable, busy = 0. ddr_index, mask, data, write_enable, burst_mode, read-data registers, owner, starve_cnt = 0. State = IDLE.
- Request accepted at edge of cycle N; ISSUE during N+1.
- With ddr_ready=1: chip_enable in N+1, WAIT from N+2.
- If ddr_operation_done arrives in cycle M ≥ N+2: done pulse and valid read data visible in M+1. Earliest next acceptance is cycle M+2.
- Back-to-back throughput: one operation per (DDR latency + 3) cycles.
- Simultaneous valids: exactly one ready high; the losers keep valid asserted and are not latched.
- Reset asserted mid-operation: immediate return to reset values. No done pulse for the aborted request.
- Valid deasserted before acceptance: no effect; nothing latched.

## Test plan
- Single load: opload_index=19'h00123 valid in IDLE, ddr_ready=1, ddr_operation_done 3 cycles after chip_enable with data 64'hDEADBEEF_CAFEF00D.
  - Expect: ready 1 cycle; chip_enable 1 cycle with index 0x123, write_enable=0, burst=0.
  - Expect: opload_operation_done 1 cycle later with that data.
- Store: index 0x7FFFF, mask 64'hFF, data 64'h55.
  - Expect: ddr_write_enable=1, ddr mask/data = 0xFF/0x55 from ISSUE to RESP, opstore_operation_done once.
- Contention, STARVE_LIMIT=4: all three valid continuously.
  - Expect grant sequence load, load, load, load, fetch, load, …
  - Expect fetch done to carry ddr_pc_read_inst and ddr_burst_mode=1 during its operation.
- ddr_ready held 0 for 5 cycles in ISSUE.
  - Expect no chip_enable until ddr_ready=1, then exactly one pulse.
- Reset asserted during WAIT, then ddr_operation_done pulses after release.
  - Expect all outputs 0, no done pulse, state IDLE; a new request is serviced normally.
